// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scanner for a 4x4 active-low keypad with whole-frame debounce.
// Drives one column low at a time, samples synchronized rows at the end of each dwell,
// then classifies each four-column frame as no key, one key or several keys.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (key_pulse re-fires while one key stays held).
module keypad_scan_ctrl #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 125
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pulse,
    output logic       multi_key
);
    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_SCANS);
    // An illegal parameter set leaves the scanner idle instead of producing bogus codes.
    localparam bit CFG_OK = (SCAN_TICKS >= 4) && (DEBOUNCE_SCANS >= 1) && (REPEAT_SCANS >= 1);

    // Frame class = {kind, code}; code is zero unless exactly one key is down.
    localparam logic [1:0] K_NONE  = 2'd0;
    localparam logic [1:0] K_ONE   = 2'd1;
    localparam logic [1:0] K_MULTI = 2'd2;

    typedef enum logic {S_SCAN = 1'b0, S_EVAL = 1'b1} state_t;
    state_t r_state, w_state_next;

    logic [3:0]    r_row_meta, r_row_sync;
    logic [3:0]    w_row_hit;
    logic [TW-1:0] r_tick;
    logic [1:0]    r_col;
    logic [3:0]    r_col_n;
    logic [15:0]   r_frame;
    logic          w_last_tick, w_sample, w_eval;
    logic [4:0]    w_hits;
    logic [3:0]    w_hit_code;
    logic [5:0]    w_cls;
    logic [5:0]    r_cand, r_acc;
    logic [DW-1:0] r_stable, w_stable_next;
    logic          w_accept;
    logic [3:0]    r_key_code;
    logic          r_key_valid, r_key_pulse, r_multi_key;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] r_rep;
`endif

    // Key legend; index is {column, row} with row 0 on row_n[3].
    function automatic logic [3:0] key_lut(input logic [3:0] idx);
        case (idx)
            4'h0: key_lut = 4'h1;  4'h1: key_lut = 4'h4;  4'h2: key_lut = 4'h7;  4'h3: key_lut = 4'h0;
            4'h4: key_lut = 4'h2;  4'h5: key_lut = 4'h5;  4'h6: key_lut = 4'h8;  4'h7: key_lut = 4'hF;
            4'h8: key_lut = 4'h3;  4'h9: key_lut = 4'h6;  4'hA: key_lut = 4'h9;  4'hB: key_lut = 4'hE;
            4'hC: key_lut = 4'hA;  4'hD: key_lut = 4'hB;  4'hE: key_lut = 4'hC;  default: key_lut = 4'hD;
        endcase
    endfunction

    // Two-flop synchronizer; idle (pulled-up) rows read as all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_n;
            r_row_sync <= r_row_meta;
        end
    end

    // Row r of the current column is pressed when row_n[3-r] is pulled low.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign w_row_hit[gi] = ~r_row_sync[3-gi];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_SCAN;
        else     r_state <= w_state_next;
    end

    // Next state: evaluate once the last column has been sampled.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SCAN:  if (w_sample && (r_col == 2'd3)) w_state_next = S_EVAL;
            default: w_state_next = S_SCAN;
        endcase
    end

    // FSM decoded controls.
    always_comb begin
        w_last_tick = (r_tick == LAST_TICK);
        w_sample    = CFG_OK && (r_state == S_SCAN) && w_last_tick;
        w_eval      = (r_state == S_EVAL);
    end

    // Dwell counter and column drive; the EVAL cycle doubles as tick 0 of column 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick  <= '0;
            r_col   <= 2'd0;
            r_col_n <= 4'b0111;
        end else if (w_eval) begin
            r_tick <= TW'(1);
        end else if (w_sample) begin
            r_tick  <= '0;
            r_col   <= r_col + 2'd1;
            r_col_n <= {r_col_n[0], r_col_n[3:1]};
        end else begin
            r_tick <= r_tick + TW'(1);
        end
    end

    // Frame accumulator: one nibble per column, cleared once the frame is classified.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame <= '0;
        end else if (w_eval) begin
            r_frame <= '0;
        end else if (w_sample) begin
            r_frame[{r_col, 2'b00} +: 4] <= w_row_hit;
        end
    end

    // Classify the completed frame by how many keys it contains.
    always_comb begin
        w_hits     = '0;
        w_hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_frame[i]) begin
                w_hits     = w_hits + 5'd1;
                w_hit_code = key_lut(4'(i));
            end
        end
        if (w_hits == 5'd0)      w_cls = {K_NONE, 4'h0};
        else if (w_hits == 5'd1) w_cls = {K_ONE, w_hit_code};
        else                     w_cls = {K_MULTI, 4'h0};
    end

    // Debounce: count identical consecutive frames, accept once stable and new.
    always_comb begin
        if (w_cls == r_cand) w_stable_next = (r_stable == DEB_MAX) ? r_stable : r_stable + DW'(1);
        else                 w_stable_next = DW'(1);
        w_accept = (w_stable_next == DEB_MAX) && (w_cls != r_acc);
    end

    // Candidate, accepted state and registered outputs, updated only in EVAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand      <= {K_NONE, 4'h0};
            r_stable    <= '0;
            r_acc       <= {K_NONE, 4'h0};
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_pulse <= 1'b0;
            r_multi_key <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_key_pulse <= 1'b0;
            if (w_eval) begin
                r_cand   <= w_cls;
                r_stable <= w_stable_next;
                if (w_accept) begin
                    r_acc <= w_cls;
`ifdef KEYPAD_AUTOREPEAT_EN
                    r_rep <= '0;
`endif
                    case (w_cls[5:4])
                        K_ONE: begin
                            r_key_code  <= w_cls[3:0];
                            r_key_valid <= 1'b1;
                            r_multi_key <= 1'b0;
                            r_key_pulse <= 1'b1;
                        end
                        K_MULTI: begin
                            r_key_valid <= 1'b0;
                            r_multi_key <= 1'b1;
                        end
                        default: begin
                            r_key_valid <= 1'b0;
                            r_multi_key <= 1'b0;
                        end
                    endcase
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (r_acc[5:4] == K_ONE) begin
                    if (r_rep == RW'(REPEAT_SCANS - 1)) begin
                        r_key_pulse <= 1'b1;
                        r_rep       <= '0;
                    end else begin
                        r_rep <= r_rep + RW'(1);
                    end
                end
`endif
            end
        end
    end

    assign col_n     = r_col_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_pulse = r_key_pulse;
    assign multi_key = r_multi_key;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench with a frame-level keypad model and per-cycle compare.
// Honours KEYPAD_AUTOREPEAT_EN the same way as the design.
module tb_keypad_scan_ctrl;
    localparam int ST = 8;
    localparam int DB = 2;
    localparam int RP = 3;
    localparam int FR = 4 * ST;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_n, row_n, key_code;
    logic       key_valid, key_pulse, multi_key;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RP)) dut (
        .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
        .key_code(key_code), .key_valid(key_valid), .key_pulse(key_pulse), .multi_key(multi_key)
    );

    // Keys currently held, one bit per hex legend.
    logic [15:0] pressed = 16'h0000;

    // Physical keypad: legend at column c, row r.
    function automatic int pad(input int c, input int r);
        int t [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};
        return t[c*4 + r];
    endfunction

    // Switch matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (col_n[3-c] === 1'b0 && pressed[pad(c, r)]) row_n[3-r] = 1'b0;
    end

    // Frame content: -1 no key, 16 several keys, else the legend.
    function automatic int classify(input logic [15:0] m);
        if ($countones(m) == 0) return -1;
        if ($countones(m) > 1)  return 16;
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] exp_col(input int cy);
        logic [3:0] one = 4'b1000;
        return ~(one >> ((cy % FR) / ST));
    endfunction

    // Model: a frame ends at every multiple of FR cycles; an outcome is accepted when the
    // last DB frames agree and differ from the accepted outcome.
    int         cyc, fidx, accf, acc, prev_cls;
    logic [3:0] e_code;
    logic       e_valid, e_multi, e_pulse;

    always @(posedge clk) begin
        if (rst) begin
            cyc <= 0; fidx <= 0; accf <= 0; acc <= -1; prev_cls <= -2;
            e_code <= 4'h0; e_valid <= 1'b0; e_multi <= 1'b0; e_pulse <= 1'b0;
        end else begin
            cyc     <= cyc + 1;
            e_pulse <= 1'b0;
            if (cyc != 0 && cyc % FR == 0) begin
                fidx     <= fidx + 1;
                prev_cls <= classify(pressed);
                if (classify(pressed) == prev_cls && classify(pressed) != acc) begin
                    acc  <= classify(pressed);
                    accf <= fidx + 1;
                    if (classify(pressed) == 16) begin
                        e_valid <= 1'b0; e_multi <= 1'b1;
                    end else if (classify(pressed) < 0) begin
                        e_valid <= 1'b0; e_multi <= 1'b0;
                    end else begin
                        e_code <= 4'(classify(pressed)); e_valid <= 1'b1;
                        e_multi <= 1'b0; e_pulse <= 1'b1;
                    end
                end else if (AR && acc >= 0 && acc < 16 && ((fidx + 1 - accf) % RP == 0)) begin
                    e_pulse <= 1'b1;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulses = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Compare process: every output against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("col_n",     {4'h0, col_n},     {4'h0, exp_col(cyc)});
            check("key_code",  {4'h0, key_code},  {4'h0, e_code});
            check("key_valid", {7'h0, key_valid}, {7'h0, e_valid});
            check("multi_key", {7'h0, multi_key}, {7'h0, e_multi});
            check("key_pulse", {7'h0, key_pulse}, {7'h0, e_pulse});
        end
        if (key_pulse === 1'b1) n_pulses++;
    end

    // Step to the cycle just after a frame boundary (outputs of that frame visible).
    task automatic align();
        int guard = 0;
        while (cyc % FR != 1 && guard < 2 * FR) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2 * FR) begin
            n_tests++; n_fail++;
            $display("FAIL align: frame boundary not reached within %0d cycles", 2 * FR);
        end
    endtask

    // Hold a key set for nfr whole frames.
    task automatic hold(input logic [15:0] mask, input int nfr);
        for (int f = 0; f < nfr; f++) begin
            align();
            pressed = mask;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 4 * FR) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4 * FR) begin
            n_tests++; n_fail++;
            $display("FAIL wait_cyc: cycle %0d not reached", n);
        end
    endtask

    initial begin : watchdog
        #(200000 * 10);
        n_tests++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : stim
        logic [3:0] cols [4] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
        int base;

        // 1. Reset state and column sequence.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_col_n",     {4'h0, col_n}, 8'h07);
        check("rst_key_code",  {4'h0, key_code}, 8'h00);
        check("rst_flags",     {5'h0, key_valid, key_pulse, multi_key}, 8'h00);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wait_cyc(8 * k);
            check($sformatf("col_seq_%0d", 8 * k), {4'h0, col_n}, {4'h0, cols[k-1]});
        end

        // 2. Key 5 held: accepted after two frames with one pulse.
        base = n_pulses;
        hold(16'h0001 << 5, 3);
        align(); @(negedge clk);
        check("k5_code",   {4'h0, key_code}, 8'h05);
        check("k5_valid",  {7'h0, key_valid}, 8'h01);
        check("k5_pulses", 8'(n_pulses - base), 8'd1);
        hold(16'h0000, 3);

        // 3. Key D bouncing every frame: no acceptance.
        base = n_pulses;
        for (int i = 0; i < 3; i++) begin
            hold(16'h0001 << 13, 1);
            hold(16'h0000, 1);
        end
        align(); @(negedge clk);
        check("bounce_pulses", 8'(n_pulses - base), 8'd0);
        check("bounce_valid",  {7'h0, key_valid}, 8'h00);
        check("bounce_code",   {4'h0, key_code}, 8'h05);

        // 4. Keys 1 and F together, then release.
        base = n_pulses;
        hold((16'h0001 << 1) | (16'h0001 << 15), 3);
        align(); @(negedge clk);
        check("multi_on",    {7'h0, multi_key}, 8'h01);
        check("multi_valid", {7'h0, key_valid}, 8'h00);
        hold(16'h0000, 2);
        align(); @(negedge clk);
        check("multi_off",    {7'h0, multi_key}, 8'h00);
        check("multi_code",   {4'h0, key_code}, 8'h05);
        check("multi_pulses", 8'(n_pulses - base), 8'd0);

        // 5. Key 9 then A without release, then reset mid-frame.
        base = n_pulses;
        hold(16'h0001 << 9, 3);
        hold(16'h0001 << 10, 3);
        align(); @(negedge clk);
        check("roll_code",   {4'h0, key_code}, 8'h0A);
        check("roll_pulses", 8'(n_pulses - base), 8'd2);
        pressed = 16'h0000;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_col_n", {4'h0, col_n}, 8'h07);
        check("midrst_code",  {4'h0, key_code}, 8'h00);
        check("midrst_flags", {5'h0, key_valid, key_pulse, multi_key}, 8'h00);
        rst = 1'b0;

        // 6. Key 0 held 12 frames: one pulse, or repeats every RP frames.
        base = n_pulses;
        hold(16'h0001, 12);
        hold(16'h0000, 3);
        align(); @(negedge clk);
        check("repeat_pulses", 8'(n_pulses - base), AR ? 8'd4 : 8'd1);
        check("repeat_code",   {4'h0, key_code}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
